// File: rtl/fir_coef_loader.sv
// rtl/fir_coef_loader.sv - streams host DA table words through a small FIFO onto the fir_filter CIN/CADDR/CLOAD port
module fir_coef_loader #(
    parameter int CW          = 19,
    parameter int AW          = 11,
    parameter int NUM_ENTRIES = 2048,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [CW-1:0] CIN,
    output logic [AW-1:0] CADDR,
    output logic          CLOAD,
    output logic          busy,
    output logic          done
);

    localparam int CNT_W = $clog2(NUM_ENTRIES) + 1;
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] NUM_C  = CNT_W'(NUM_ENTRIES);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(NUM_ENTRIES - 1);
    localparam logic [PW:0]      FULL_C = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DONE  = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t state, state_d;

    logic [CW-1:0]    mem [FIFO_DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [PW:0]      fifo_cnt;
    logic [CNT_W-1:0] acc_cnt, wr_cnt;

    logic fifo_full, fifo_empty;
    logic push, pop, clear;
    logic cload_d, busy_d, done_d;

    assign fifo_full  = (fifo_cnt == FULL_C);
    assign fifo_empty = (fifo_cnt == '0);
    assign s_ready    = (state == S_LOAD) && !fifo_full && (acc_cnt < NUM_C);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Abort outranks both the host handshake and the drain in LOAD.
    always_comb begin
        state_d = state;
        push    = 1'b0;
        pop     = 1'b0;
        clear   = 1'b0;
        cload_d = 1'b0;
        busy_d  = busy;
        done_d  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_LOAD;
                    clear   = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    state_d = S_FLUSH;
                    clear   = 1'b1;
                end else begin
                    push    = s_valid && s_ready;
                    pop     = !fifo_empty;
                    cload_d = pop;
                    if (pop && (wr_cnt == LAST_C)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            S_FLUSH: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
            acc_cnt  <= '0;
            wr_cnt   <= '0;
            CIN      <= '0;
            CADDR    <= '0;
            CLOAD    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            CLOAD <= cload_d;
            busy  <= busy_d;
            done  <= done_d;
            if (clear) begin
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                fifo_cnt <= '0;
                acc_cnt  <= '0;
                wr_cnt   <= '0;
            end else begin
                if (push) begin
                    wr_ptr  <= wr_ptr + PW'(1);
                    acc_cnt <= acc_cnt + CNT_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                    CIN    <= mem[rd_ptr];
                    CADDR  <= AW'(wr_cnt);
                    wr_cnt <= wr_cnt + CNT_W'(1);
                end
                case ({push, pop})
                    2'b10:   fifo_cnt <= fifo_cnt + (PW+1)'(1);
                    2'b01:   fifo_cnt <= fifo_cnt - (PW+1)'(1);
                    default: fifo_cnt <= fifo_cnt;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fir_coef_loader.sv
// tb/tb_fir_coef_loader.sv - randomized bench for fir_coef_loader against an in-order write queue model
module tb_fir_coef_loader;

    localparam int CW = 19;
    localparam int AW = 11;
    localparam int N  = 2048;

    logic          clk = 1'b0;
    logic          resetn, start, abort, s_valid;
    logic [CW-1:0] s_data;
    logic          s_ready, CLOAD, busy, done;
    logic [CW-1:0] CIN;
    logic [AW-1:0] CADDR;

    always #5 clk = ~clk;

    fir_coef_loader #(.CW(CW), .AW(AW), .NUM_ENTRIES(N), .FIFO_DEPTH(4)) dut (
        .clk(clk), .resetn(resetn), .start(start), .abort(abort),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .CIN(CIN), .CADDR(CADDR), .CLOAD(CLOAD), .busy(busy), .done(done)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: every accepted word must come out once, in order, at the next address.
    logic [CW-1:0] q[$];
    int  hits[N];
    int  exp_addr, acc_n, done_cnt, mon_bad;
    bit  cont_mode, prev_cload, prev_busy, mon_en;
    logic [CW-1:0] mon_w;

    task automatic model_start();
        q.delete();
        exp_addr = 0;
        acc_n    = 0;
        for (int i = 0; i < N; i++) hits[i] = 0;
    endtask

    always @(negedge clk) begin
        if (mon_en && resetn) begin
            if (cont_mode && exp_addr > 0 && exp_addr < N)
                check("no_gap", 32'(CLOAD), 1);
            if (CLOAD) begin
                if (q.size() == 0) begin
                    check("spurious_cload", 32'(CADDR), 32'hFFFF_FFFF);
                end else begin
                    mon_w = q.pop_front();
                    check("cin", 32'(CIN), 32'(mon_w));
                    check("caddr", 32'(CADDR), exp_addr);
                    if (exp_addr < N) hits[exp_addr]++;
                    exp_addr++;
                end
            end
            if (done) begin
                check("done_after_cload", 32'(prev_cload), 1);
                check("done_words", exp_addr, N);
                check("done_busy_low", 32'(busy), 0);
                check("busy_before_done", 32'(prev_busy), 1);
                mon_bad = 0;
                for (int i = 0; i < N; i++) if (hits[i] != 1) mon_bad++;
                check("all_once", mon_bad, 0);
                done_cnt++;
            end
            if (s_ready) check("ready_needs_busy", 32'(busy), 1);
            if (s_valid && s_ready && !abort) begin
                check("accept_limit", 32'(acc_n < N), 1);
                q.push_back(s_data);
                acc_n++;
            end
            prev_cload = CLOAD;
            prev_busy  = busy;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input bit gaps, input int mid_start, input int abort_at);
        int d0, sent;
        bit acc, fin;
        d0 = done_cnt; sent = 0; acc = 0; fin = 0;
        model_start();
        cont_mode = 0;
        s_valid = 0;
        start = 1;
        tick();
        start = 0;
        cont_mode = !gaps;
        for (int cyc = 0; cyc < 12000 && !fin; cyc++) begin
            if (acc) sent++;
            if (!s_valid || acc) begin
                s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                s_data  = gaps ? CW'($urandom) : (CW'(sent) ^ 19'h5A5A5);
            end
            start = (cyc == mid_start);
            if (abort_at >= 0 && exp_addr >= abort_at) begin
                abort = 1; s_valid = 0; cont_mode = 0;
            end
            @(negedge clk);
            acc = s_valid && s_ready && !abort;
            tick();
            start = 0;
            if (abort) begin
                abort = 0;
                fin = 1;
                check("abort_cload", 32'(CLOAD), 0);
                q.delete();
                check("flush_busy", 32'(busy), 1);
                tick();
                check("abort_busy", 32'(busy), 0);
                check("abort_ready", 32'(s_ready), 0);
                repeat (5) tick();
                check("abort_no_done", done_cnt - d0, 0);
            end else if (done_cnt != d0) begin
                fin = 1;
                cont_mode = 0;
                s_valid = 1;
                repeat (10) begin
                    check("post_done_ready", 32'(s_ready), 0);
                    tick();
                end
                s_valid = 0;
                check("single_done", done_cnt - d0, 1);
                check("idle_busy", 32'(busy), 0);
            end
        end
        if (!fin) check("load_timeout", 0, 1);
        cont_mode = 0;
        s_valid = 0;
    endtask

    initial begin
        bit acc;
        resetn = 0; start = 0; abort = 0; s_valid = 0; s_data = '0;
        mon_en = 0; done_cnt = 0; cont_mode = 0; prev_cload = 0; prev_busy = 0;
        model_start();
        repeat (3) tick();
        check("rst_cin", 32'(CIN), 0);
        check("rst_caddr", 32'(CADDR), 0);
        check("rst_cload", 32'(CLOAD), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_ready", 32'(s_ready), 0);
        resetn = 1;
        mon_en = 1;
        tick();
        check("idle_busy0", 32'(busy), 0);
        check("idle_ready0", 32'(s_ready), 0);

        feed(1'b0, -1, -1);
        feed(1'b1, -1, -1);
        feed(1'b0, -1, 100);
        feed(1'b0, -1, -1);

        start = 1; abort = 1;
        tick();
        start = 0; abort = 0;
        tick();
        check("start_abort_busy", 32'(busy), 0);
        check("start_abort_ready", 32'(s_ready), 0);
        feed(1'b1, 700, -1);

        model_start();
        start = 1;
        tick();
        start = 0;
        s_valid = 1;
        s_data = CW'($urandom);
        repeat (40) begin
            @(negedge clk);
            acc = s_valid && s_ready && !abort;
            tick();
            if (acc) s_data = CW'($urandom);
        end
        #2;
        resetn = 0;
        #1;
        check("arst_cin", 32'(CIN), 0);
        check("arst_caddr", 32'(CADDR), 0);
        check("arst_cload", 32'(CLOAD), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_done", 32'(done), 0);
        check("arst_ready", 32'(s_ready), 0);
        mon_en = 0;
        s_valid = 0;
        model_start();
        repeat (2) tick();
        resetn = 1;
        mon_en = 1;
        repeat (3) begin
            tick();
            check("post_rst_busy", 32'(busy), 0);
            check("post_rst_ready", 32'(s_ready), 0);
        end
        feed(1'b0, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
